wb_merge: RTL and testbench
===========================

// Module: wb_merge
// PURPOSE
//  Writeback merge stage sitting directly upstream of the register file write port.
//  Merges two result sources onto the single RF write port (regWriteEn/rd_in/regWriteData):
//   - in-order pipeline results, which cannot be stalled;
//   - out-of-order mul/div results, which are buffered in a small FIFO.
//  Exports a pending-destination mask so decode can stall on RAW hazards against queued results.
// PARAMETERS
//  DATA_W   32  result width (DType)
//  ADDR_W   5   register index width (Gr); 2**ADDR_W architectural registers
//  Q_DEPTH  4   mul/div result FIFO entries; power of two, >=2
// PORTS
//  clk           in   1                 clock; FIFO and output regs update on posedge
//  reset         in   1                 asynchronous, active-high
//  pipe_valid    in   1                 pipeline result valid this cycle (no backpressure)
//  pipe_rd       in   ADDR_W            pipeline destination register
//  pipe_data     in   DATA_W            pipeline result
//  md_valid      in   1                 mul/div result offered
//  md_ready      out  1                 FIFO can accept; = (count < Q_DEPTH)
//  md_rd         in   ADDR_W            mul/div destination
//  md_data       in   DATA_W            mul/div result
//  wb_en         out  1                 to RF regWriteEn
//  wb_rd         out  ADDR_W            to RF rd_in
//  wb_data       out  DATA_W            to RF regWriteData
//  pending_mask  out  2**ADDR_W         bit i=1: a live queued entry targets register i
//  q_count       out  $clog2(Q_DEPTH)+1 FIFO occupancy, including killed entries
// BEHAVIOUR
//  Reset (async, immediate): wb_en=0, wb_rd=0, wb_data=0, FIFO emptied, q_count=0, pending_mask=0.
//   md_ready=1 while reset is held.
//  Outputs are registered, so source-to-RF latency is 1 cycle.
//   The RF commits on the following negedge; no extra bypass is needed here.
//  FIFO entry = {live, rd, data}. head/tail pointers wrap modulo Q_DEPTH. Counter tracks occupancy.
//  Enqueue: md_valid & md_ready.
//   - md_rd==0: handshake completes, nothing stored.
//   - otherwise the entry is stored with live=1.
//  Per-cycle selection, evaluated in priority order:
//   1. pipe_valid & pipe_rd!=0: register {1, pipe_rd, pipe_data}.
//   2. Else, head live: register the head entry and pop it.
//   3. Else, head killed: pop it; wb_en=0 next cycle.
//   4. Else: wb_en=0. wb_rd and wb_data hold their previous values.
//  Killed head entries may also be popped in a cycle where rule 1 fires (dead entries free slots early).
//  WAW kill: when pipe_valid & pipe_rd!=0, every live queued entry with rd==pipe_rd is cleared to live=0.
//   The pipeline result is the younger one.
//   An entry enqueued in the same cycle with md_rd==pipe_rd is stored as live=0.
//  pipe_valid with pipe_rd==0: ignored, wb_en=0 unless the FIFO drains that cycle.
//  Simultaneous enqueue and pop: count is unchanged.
//   md_ready depends only on count (no combinational path from dequeue).
//   A full FIFO therefore refuses in the cycle it pops.
//  pending_mask is combinational from FIFO contents: OR over live entries of onehot(rd).
//   The incoming md offer is not included until it is stored.
//  The FIFO must not overflow or underflow; assert count <= Q_DEPTH.
//  Mul/div results still in flight (not yet offered) are decode's responsibility.
//  Reset mid-operation discards all queued results.
// TESTING
//  1. Reset mid-drain with 3 entries queued -> wb_en=0 and q_count=0 immediately; md_ready=1.
//  2. pipe r5=0x11 at cycle 0 -> wb_en=1, wb_rd=5, wb_data=0x11 at cycle 1; wb_en=0 at cycle 2.
//  3. md r7=0xAA offered while pipe_valid is held 3 cycles ->
//     pending_mask[7]=1 throughout; r7 written in the first cycle after pipe_valid drops.
//  4. Fill 4 entries (r1..r4) with pipe_valid held high -> md_ready=0, q_count=4.
//     Drop pipe_valid -> r1, r2, r3, r4 written in order on consecutive cycles.
//  5. Queue r9=0x1, then pipe r9=0x2 -> r9 written once with 0x2.
//     The killed entry pops with no write; pending_mask[9]=0 right after the kill.
//  6. md r0=0x5 and pipe r0=0x6 -> handshake completes, q_count stays 0, wb_en never asserts.

Source files
------------

// File: rtl/wb_merge_if.sv
// Bus bundle for the writeback merge stage: pipeline result, mul/div handshake,
// register-file write port and hazard/occupancy status.
interface wb_merge_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int Q_DEPTH = 4
);
    localparam int NREG = 1 << ADDR_W;
    localparam int CW   = $clog2(Q_DEPTH) + 1;

    // md_valid/md_ready: a result transfers on a rising clk edge where both are high.
    // The producer holds md_rd/md_data stable while md_valid waits for md_ready, and
    // md_ready never depends on md_valid.
    logic              pipe_valid;
    logic [ADDR_W-1:0] pipe_rd;
    logic [DATA_W-1:0] pipe_data;
    logic              md_valid;
    logic              md_ready;
    logic [ADDR_W-1:0] md_rd;
    logic [DATA_W-1:0] md_data;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [NREG-1:0]   pending_mask;
    logic [CW-1:0]     q_count;

    modport master (
        output pipe_valid, pipe_rd, pipe_data, md_valid, md_rd, md_data,
        input  md_ready, wb_en, wb_rd, wb_data, pending_mask, q_count
    );

    modport slave (
        input  pipe_valid, pipe_rd, pipe_data, md_valid, md_rd, md_data,
        output md_ready, wb_en, wb_rd, wb_data, pending_mask, q_count
    );
endinterface

// File: rtl/wb_merge.sv
// Merges unstallable pipeline results and FIFO-buffered mul/div results onto the
// single register-file write port, with WAW kill and a pending-destination mask.
module wb_merge #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int Q_DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    wb_merge_if.slave bus
);
    localparam int PTR_W = $clog2(Q_DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam int NREG  = 1 << ADDR_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(Q_DEPTH);

    logic              live_q [Q_DEPTH];
    logic [ADDR_W-1:0] rd_q   [Q_DEPTH];
    logic [DATA_W-1:0] data_q [Q_DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CW-1:0]     count;

    logic              wb_en_r;
    logic [ADDR_W-1:0] wb_rd_r;
    logic [DATA_W-1:0] wb_data_r;
    logic [NREG-1:0]   mask;

    logic pipe_hit, head_live, head_dead, do_pop, do_enq, enq_live, ready;

    // live bits are cleared on pop, so an empty slot never reads as live.
    always_comb begin
        pipe_hit  = bus.pipe_valid && (bus.pipe_rd != '0);
        head_live = live_q[head];
        head_dead = (count != '0) && !live_q[head];
        do_pop    = head_dead || (head_live && !pipe_hit);
        ready     = (count < DEPTH_C);
        do_enq    = bus.md_valid && ready && (bus.md_rd != '0);
        enq_live  = !(pipe_hit && (bus.md_rd == bus.pipe_rd));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < Q_DEPTH; i++) live_q[i] <= 1'b0;
        end else begin
            for (int i = 0; i < Q_DEPTH; i++) begin
                if (pipe_hit && (rd_q[i] == bus.pipe_rd)) live_q[i] <= 1'b0;
            end
            if (do_pop) live_q[head] <= 1'b0;
            if (do_enq) live_q[tail] <= enq_live;
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            rd_q[tail]   <= bus.md_rd;
            data_q[tail] <= bus.md_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_pop) head <= head + PTR_W'(1);
            if (do_enq) tail <= tail + PTR_W'(1);
            case ({do_enq, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Pipeline wins the port; wb_rd/wb_data hold when nothing is written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_en_r   <= 1'b0;
            wb_rd_r   <= '0;
            wb_data_r <= '0;
        end else if (pipe_hit) begin
            wb_en_r   <= 1'b1;
            wb_rd_r   <= bus.pipe_rd;
            wb_data_r <= bus.pipe_data;
        end else if (head_live) begin
            wb_en_r   <= 1'b1;
            wb_rd_r   <= rd_q[head];
            wb_data_r <= data_q[head];
        end else begin
            wb_en_r   <= 1'b0;
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < Q_DEPTH; i++) begin
            if (live_q[i]) mask[rd_q[i]] = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!reset) assert (count <= DEPTH_C);
    end

    assign bus.md_ready     = ready;
    assign bus.wb_en        = wb_en_r;
    assign bus.wb_rd        = wb_rd_r;
    assign bus.wb_data      = wb_data_r;
    assign bus.pending_mask = mask;
    assign bus.q_count      = count;
endmodule

// File: tb/tb_wb_merge.sv
// Self-checking bench for wb_merge: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_wb_merge;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int Q_DEPTH = 4;

    typedef struct packed {
        logic              live;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ent_t              mq[$];
    logic              exp_en;
    logic [ADDR_W-1:0] exp_rd;
    logic [DATA_W-1:0] exp_data;

    wb_merge_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .Q_DEPTH(Q_DEPTH)) bus ();

    wb_merge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .Q_DEPTH(Q_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (mq[i]) if (mq[i].live) m[mq[i].rd] = 1'b1;
        return m;
    endfunction

    task automatic set_idle();
        bus.pipe_valid = 1'b0;
        bus.md_valid   = 1'b0;
    endtask

    // Compare at negedge, advance the model with the inputs held for this edge,
    // then return just after the posedge so the caller can drive the next inputs.
    task automatic cycle();
        logic hit, rdy;
        @(negedge clk);
        check("wb_en", bus.wb_en, exp_en);
        check("wb_rd", bus.wb_rd, exp_rd);
        check("wb_data", bus.wb_data, exp_data);
        check("md_ready", bus.md_ready, (mq.size() < Q_DEPTH));
        check("q_count", bus.q_count, mq.size());
        check("pending_mask", bus.pending_mask, model_mask());
        hit = bus.pipe_valid && (bus.pipe_rd != 0);
        rdy = (mq.size() < Q_DEPTH);
        exp_en = 1'b0;
        if (hit) begin
            exp_en = 1'b1; exp_rd = bus.pipe_rd; exp_data = bus.pipe_data;
        end
        if (mq.size() > 0) begin
            if (!mq[0].live) void'(mq.pop_front());
            else if (!hit) begin
                exp_en = 1'b1; exp_rd = mq[0].rd; exp_data = mq[0].data;
                void'(mq.pop_front());
            end
        end
        if (hit) foreach (mq[i]) if (mq[i].rd == bus.pipe_rd) mq[i].live = 1'b0;
        if (bus.md_valid && rdy && bus.md_rd != 0)
            mq.push_back('{live: !(hit && bus.md_rd == bus.pipe_rd), rd: bus.md_rd, data: bus.md_data});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_wb_en", bus.wb_en, 0);
        check("rst_q_count", bus.q_count, 0);
        check("rst_md_ready", bus.md_ready, 1);
        check("rst_mask", bus.pending_mask, 0);
        mq.delete();
        exp_en = 1'b0; exp_rd = '0; exp_data = '0;
        @(posedge clk);
        #1;
        check("rst_hold_ready", bus.md_ready, 1);
        reset = 1'b0;
    endtask

    task automatic pipe(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
        bus.pipe_valid = 1'b1; bus.pipe_rd = rd; bus.pipe_data = d;
    endtask

    task automatic md(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
        bus.md_valid = 1'b1; bus.md_rd = rd; bus.md_data = d;
    endtask

    initial begin
        bus.pipe_valid = 1'b0; bus.pipe_rd = '0; bus.pipe_data = '0;
        bus.md_valid = 1'b0; bus.md_rd = '0; bus.md_data = '0;
        do_reset();
        cycle();

        // single pipeline write, one-cycle latency
        pipe(5, 32'h11);
        cycle();
        check("t2_en", bus.wb_en, 1);
        check("t2_rd", bus.wb_rd, 5);
        check("t2_data", bus.wb_data, 32'h11);
        set_idle();
        cycle();
        check("t2_en_off", bus.wb_en, 0);

        // mul/div result waits behind three pipeline cycles
        pipe(3, 32'h33); md(7, 32'hAA);
        cycle();
        bus.md_valid = 1'b0;
        check("t3_mask_a", bus.pending_mask[7], 1);
        cycle();
        check("t3_mask_b", bus.pending_mask[7], 1);
        cycle();
        check("t3_mask_c", bus.pending_mask[7], 1);
        bus.pipe_valid = 1'b0;
        cycle();
        check("t3_rd", bus.wb_rd, 7);
        check("t3_data", bus.wb_data, 32'hAA);
        cycle();

        // fill to full, then in-order drain
        pipe(20, 32'h2020);
        for (int k = 1; k <= 4; k++) begin
            md(k[ADDR_W-1:0], 32'h100 + k);
            cycle();
        end
        bus.md_valid = 1'b0;
        check("t4_ready_full", bus.md_ready, 0);
        check("t4_count_full", bus.q_count, 4);
        bus.pipe_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            check("t4_order", bus.wb_rd, k);
        end
        cycle();

        // reset mid-drain with three entries left
        pipe(21, 32'h2121);
        for (int k = 1; k <= 4; k++) begin
            md(k[ADDR_W-1:0] + 5'd10, 32'h200 + k);
            cycle();
        end
        set_idle();
        cycle();
        check("t1_count3", bus.q_count, 3);
        do_reset();
        cycle();

        // WAW kill
        pipe(3, 32'h3); md(9, 32'h1);
        cycle();
        bus.md_valid = 1'b0;
        pipe(9, 32'h2);
        cycle();
        check("t5_rd", bus.wb_rd, 9);
        check("t5_data", bus.wb_data, 32'h2);
        check("t5_mask9", bus.pending_mask[9], 0);
        set_idle();
        cycle();
        check("t5_dead_pop", bus.wb_en, 0);
        check("t5_count", bus.q_count, 0);

        // register 0 is never written or queued
        md(0, 32'h5); pipe(0, 32'h6);
        check("t6_ready", bus.md_ready, 1);
        cycle();
        check("t6_count", bus.q_count, 0);
        check("t6_en", bus.wb_en, 0);
        set_idle();
        cycle();

        // random traffic with a small register range to provoke WAW kills
        for (int n = 0; n < 400; n++) begin
            bus.pipe_valid = ($urandom_range(0, 2) == 0);
            bus.pipe_rd    = ADDR_W'($urandom_range(0, 7));
            bus.pipe_data  = $urandom;
            bus.md_valid   = ($urandom_range(0, 3) != 0);
            bus.md_rd      = ADDR_W'($urandom_range(0, 7));
            bus.md_data    = $urandom;
            if (n == 200) do_reset();
            cycle();
        end
        set_idle();
        for (int n = 0; n < 6; n++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
